// File: rtl/core_io_pkg.sv
// ----------------------------------------------------------------------------
// core_io_pkg
// Shared definitions for the core's I/O path: the output word width, the
// default output FIFO depth and the output word type used between the
// execute stage and the output port buffer.
// ----------------------------------------------------------------------------
package core_io_pkg;

    // Width of one word written by an OUT instruction.
    localparam int OUT_DATA_W     = 16;

    // Default number of queued OUT words (power of two, at least 2).
    localparam int OUT_FIFO_DEPTH = 8;

    // One output word as produced by the execute-stage ALU.
    typedef logic [15:0] out_word_t;

endpackage : core_io_pkg

// File: rtl/out_fifo_ram.sv
// ----------------------------------------------------------------------------
// out_fifo_ram
// DEPTH x DATA_W storage for the output port FIFO. One synchronous write
// port and one asynchronous read port. The array is deliberately not reset:
// the owning FIFO never presents a slot that has not been written since the
// last reset.
//
// Ports:
//   clk      in   write clock, rising edge
//   wrEn     in   write strobe
//   wrAddr   in   write slot index
//   wrData   in   word to store
//   rdAddr   in   read slot index
//   rdData   out  word held in slot rdAddr (combinational)
// ----------------------------------------------------------------------------
module out_fifo_ram
    import core_io_pkg::*;
#(
    parameter  int DATA_W = OUT_DATA_W,
    parameter  int DEPTH  = OUT_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Asynchronous read of the addressed slot.
    assign rdData = mem_r[rdAddr];

endmodule : out_fifo_ram

// File: rtl/out_port_fifo.sv
// ----------------------------------------------------------------------------
// out_port_fifo
// Queues every OUT-instruction write from the core and drains it to the
// output peripheral through a valid/ready handshake (first-word-fall-through).
// A mirror of the last accepted word keeps the legacy 16-bit `out` bus
// behaviour, and a sticky flag records any word dropped because the queue
// was full.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   i_write     in   one-cycle push strobe (core output_write)
//   i_data      in   word to push (execute-stage ALU result)
//   i_ready     in   peripheral takes the head word this cycle
//   i_clr_ovf   in   clear the sticky overflow flag
//   o_valid     out  head word available
//   o_data      out  head word, 0 when empty
//   o_full      out  queue holds DEPTH words
//   o_count     out  occupancy 0..DEPTH
//   o_overflow  out  sticky: a push was dropped
//   o_last      out  last accepted pushed word
// ----------------------------------------------------------------------------
module out_port_fifo
    import core_io_pkg::*;
#(
    parameter  int DATA_W = OUT_DATA_W,
    parameter  int DEPTH  = OUT_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_clr_ovf,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic [PTR_W:0]    o_count,
    output logic              o_overflow,
    output logic [DATA_W-1:0] o_last
);

    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]  wrPtr_r;
    logic [PTR_W-1:0]  rdPtr_r;
    logic [PTR_W:0]    count_r;
    logic              valid_r;
    logic              full_r;
    logic              overflow_r;
    logic [DATA_W-1:0] last_r;

    logic              popFire_s;
    logic              pushAccept_s;
    logic              drop_s;
    logic [PTR_W:0]    countNext_s;
    logic [DATA_W-1:0] ramRdData_s;

    // A pop needs a word already visible at the head; a full queue can still
    // take a push when the head leaves in the same cycle.
    assign popFire_s    = valid_r & i_ready;
    assign pushAccept_s = i_write & (~full_r | popFire_s);
    assign drop_s       = i_write & full_r & ~popFire_s;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        countNext_s = count_r;
        case ({pushAccept_s, popFire_s})
            2'b10:   countNext_s = count_r + CNT_ONE;
            2'b01:   countNext_s = count_r - CNT_ONE;
            default: countNext_s = count_r;
        endcase
    end

    // Pointers, occupancy, derived status flags and the legacy mirror.
    // valid/full are registered from the next count so they need no decode
    // on the output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r    <= {PTR_W{1'b0}};
            rdPtr_r    <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO;
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            last_r     <= {DATA_W{1'b0}};
        end else begin
            if (pushAccept_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
                last_r  <= i_data;
            end
            if (popFire_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            count_r <= countNext_s;
            valid_r <= (countNext_s != CNT_ZERO);
            full_r  <= (countNext_s == CNT_FULL);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (i_clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // The write is gated by rst so a reset cycle leaves no trace at all.
    out_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .wrEn   (pushAccept_s & ~rst),
        .wrAddr (wrPtr_r),
        .wrData (i_data),
        .rdAddr (rdPtr_r),
        .rdData (ramRdData_s)
    );

    // Head word; forced to zero when empty so stale slots never leak out.
    // A push only ever writes the tail slot, so the head is stable under
    // backpressure.
    always_comb begin
        o_data = {DATA_W{1'b0}};
        if (valid_r) begin
            o_data = ramRdData_s;
        end else begin
            o_data = {DATA_W{1'b0}};
        end
    end

    assign o_valid    = valid_r;
    assign o_full     = full_r;
    assign o_count    = count_r;
    assign o_overflow = overflow_r;
    assign o_last     = last_r;

endmodule : out_port_fifo

// File: tb/tb_out_port_fifo.sv
// ----------------------------------------------------------------------------
// tb_out_port_fifo
// Self-checking bench for out_port_fifo. A queue-based reference model of
// the output buffer predicts every output after each clock edge.
// ----------------------------------------------------------------------------
module tb_out_port_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_write;
    logic [15:0] i_data;
    logic        i_ready;
    logic        i_clr_ovf;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_full;
    logic [3:0]  o_count;
    logic        o_overflow;
    logic [15:0] o_last;

    int checkCnt = 0;
    int errorCnt = 0;

    // Reference model state.
    logic [15:0] mQ[$];
    logic        mOvf;
    logic [15:0] mLast;

    out_port_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .i_write    (i_write),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .i_clr_ovf  (i_clr_ovf),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errorCnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model.
    task automatic compareAll(input string ctx);
        logic [15:0] expData;
        expData = (mQ.size() != 0) ? mQ[0] : 16'h0000;
        checkValue({ctx, ".valid"},    {31'd0, o_valid},    {31'd0, mQ.size() != 0});
        checkValue({ctx, ".data"},     {16'd0, o_data},     {16'd0, expData});
        checkValue({ctx, ".count"},    {28'd0, o_count},    mQ.size());
        checkValue({ctx, ".full"},     {31'd0, o_full},     {31'd0, mQ.size() == DEPTH});
        checkValue({ctx, ".overflow"}, {31'd0, o_overflow}, {31'd0, mOvf});
        checkValue({ctx, ".last"},     {16'd0, o_last},     {16'd0, mLast});
    endtask

    // One clock cycle: drive inputs, advance the model by the queue rules,
    // sample outputs #1 after the edge.
    task automatic step(input string ctx, input logic wr, input logic [15:0] d,
                        input logic rdy, input logic clr);
        bit doPop;
        bit doPush;
        i_write   = wr;
        i_data    = d;
        i_ready   = rdy;
        i_clr_ovf = clr;
        doPop  = (mQ.size() != 0) && rdy;
        doPush = wr && ((mQ.size() < DEPTH) || doPop);
        @(posedge clk);
        #1;
        if (rst) begin
            mQ.delete();
            mOvf  = 1'b0;
            mLast = 16'h0000;
        end else begin
            if (doPop) begin
                void'(mQ.pop_front());
            end
            if (doPush) begin
                mQ.push_back(d);
                mLast = d;
            end
            if (wr && !doPush) begin
                mOvf = 1'b1;
            end else if (clr) begin
                mOvf = 1'b0;
            end
        end
        compareAll(ctx);
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            step("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_write   = 1'b0;
        i_data    = 16'h0000;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        mOvf      = 1'b0;
        mLast     = 16'h0000;

        // Reset then idle.
        doReset(2);
        step("idle", 1'b0, 16'h0000, 1'b0, 1'b0);
        checkValue("idle_valid", {31'd0, o_valid}, 32'd0);

        // Single push then drain.
        step("push1", 1'b1, 16'h00A5, 1'b0, 1'b0);
        checkValue("push1_head", {16'd0, o_data}, 32'h0000_00A5);
        step("pop1", 1'b0, 16'h0000, 1'b1, 1'b0);
        checkValue("pop1_count", {28'd0, o_count}, 32'd0);

        // Fill, overflow, drain in order.
        for (int k = 1; k <= 8; k++) begin
            step("fill", 1'b1, 16'(k), 1'b0, 1'b0);
        end
        checkValue("fill_full", {31'd0, o_full}, 32'd1);
        step("ovf", 1'b1, 16'h0009, 1'b0, 1'b0);
        checkValue("ovf_flag", {31'd0, o_overflow}, 32'd1);
        checkValue("ovf_last", {16'd0, o_last}, 32'h0000_0008);
        for (int k = 1; k <= 8; k++) begin
            checkValue("drain_order", {16'd0, o_data}, k);
            step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Full with simultaneous push and pop.
        step("clr", 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step("fill2", 1'b1, 16'(k), 1'b0, 1'b0);
        end
        step("pushpop_full", 1'b1, 16'h0009, 1'b1, 1'b0);
        checkValue("pp_head", {16'd0, o_data}, 32'h0000_0002);
        checkValue("pp_ovf", {31'd0, o_overflow}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step("pp_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Empty with push and ready together: no pop.
        step("empty_pp", 1'b1, 16'h1234, 1'b1, 1'b0);
        checkValue("empty_pp_count", {28'd0, o_count}, 32'd1);
        step("empty_pp_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Wrap-around with toggling backpressure.
        for (int k = 0; k < 24; k++) begin
            step("wrap", (k < 12), 16'hC000 + 16'(k), k[0], 1'b0);
        end
        for (int k = 0; k < 12; k++) begin
            step("wrap_tail", 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Reset mid-drain.
        for (int k = 0; k < 5; k++) begin
            step("pre_rst", 1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0);
        end
        step("mid_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        doReset(1);
        checkValue("rst_count", {28'd0, o_count}, 32'd0);
        checkValue("rst_valid", {31'd0, o_valid}, 32'd0);

        // Drop and clear in the same cycle: set wins; then clear alone.
        for (int k = 0; k < 8; k++) begin
            step("fill3", 1'b1, 16'hB000 + 16'(k), 1'b0, 1'b0);
        end
        step("drop_clr", 1'b1, 16'hBEEF, 1'b0, 1'b1);
        checkValue("drop_clr_ovf", {31'd0, o_overflow}, 32'd1);
        step("clr_only", 1'b0, 16'h0000, 1'b0, 1'b1);
        checkValue("clr_only_ovf", {31'd0, o_overflow}, 32'd0);

        // Randomized traffic: producer-heavy then consumer-heavy, with rare
        // resets and overflow clears.
        for (int k = 0; k < 600; k++) begin
            logic wr;
            logic rdy;
            logic clr;
            if (k < 300) begin
                wr  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) == 0);
            end else begin
                wr  = ($urandom_range(0, 2) == 0);
                rdy = ($urandom_range(0, 3) != 0);
            end
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step("rand", wr, 16'($urandom), rdy, clr);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
        $finish;
    end

endmodule : tb_out_port_fifo
